// File: rtl/muldiv_unit_if.sv
// Request/response bundle between the execute stage and the mul/div unit.
// The master drives operands and handshakes; the slave returns the result.
interface muldiv_unit_if #(
    parameter int XLEN = 64
);
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [2:0]      op;
    logic            word;
    logic [XLEN-1:0] src_a;
    logic [XLEN-1:0] src_b;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic            busy;

    modport master (
        output flush, in_valid, op, word, src_a, src_b, out_ready,
        input  in_ready, out_valid, result, busy
    );

    modport slave (
        input  flush, in_valid, op, word, src_a, src_b, out_ready,
        output in_ready, out_valid, result, busy
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative radix-2 RV64M multiply/divide unit (shift-add / restoring).
// Define MULDIV_EARLY_OUT_EN to finish div-by-zero, overflow and zero-multiply at once.
module muldiv_unit #(
    parameter int XLEN = 64,
    parameter int WLEN = 32
) (
    input  logic         clk,
    input  logic         reset,
    muldiv_unit_if.slave bus
);
    localparam int CW = $clog2(XLEN + 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t          state;
    logic [2:0]      op_q;
    logic            word_q;
    logic            neg_q;
    logic            rneg_q;
    logic            div0_q;
    logic [XLEN:0]   hi;
    logic [XLEN-1:0] lo;
    logic [XLEN-1:0] b_q;
    logic [XLEN-1:0] a_q;
    logic [CW-1:0]   cnt;
    logic [XLEN-1:0] res_q;
    logic            out_valid_q;

    function automatic logic [XLEN-1:0] sext_w(input logic [XLEN-1:0] x);
        return XLEN'($signed(x[WLEN-1:0]));
    endfunction

    logic            wd;
    logic            is_div;
    logic            a_sgn;
    logic            b_sgn;
    logic            a_neg;
    logic            b_neg;
    logic            div0;
    logic [XLEN-1:0] a_ext;
    logic [XLEN-1:0] b_ext;
    logic [XLEN-1:0] mag_a;
    logic [XLEN-1:0] mag_b;
    logic [XLEN-1:0] a_fix;

    always_comb begin
        wd     = (XLEN == 64) && bus.word;
        is_div = bus.op[2];
        a_sgn  = (bus.op == 3'd1) || (bus.op == 3'd2) ||
                 (bus.op == 3'd4) || (bus.op == 3'd6);
        b_sgn  = (bus.op == 3'd1) || (bus.op == 3'd4) ||
                 (bus.op == 3'd6);
        a_ext  = bus.src_a;
        b_ext  = bus.src_b;
        if (wd) begin
            a_ext = a_sgn ? sext_w(bus.src_a) : XLEN'(bus.src_a[WLEN-1:0]);
            b_ext = b_sgn ? sext_w(bus.src_b) : XLEN'(bus.src_b[WLEN-1:0]);
        end
        a_neg = a_sgn && a_ext[XLEN-1];
        b_neg = b_sgn && b_ext[XLEN-1];
        mag_a = a_neg ? -a_ext : a_ext;
        mag_b = b_neg ? -b_ext : b_ext;
        div0  = is_div && (mag_b == '0);
        a_fix = wd ? sext_w(a_ext) : a_ext;
    end

`ifdef MULDIV_EARLY_OUT_EN
    logic            ovf;
    logic            mulz;
    logic            early;
    logic [XLEN-1:0] early_res;

    always_comb begin
        ovf   = is_div && !bus.op[0] && a_neg && b_neg &&
                (mag_b == XLEN'(1)) &&
                (mag_a == (XLEN'(1) << (wd ? WLEN - 1 : XLEN - 1)));
        mulz  = !is_div && ((mag_a == '0) || (mag_b == '0));
        early = div0 || ovf || mulz;
        early_res = '0;
        if (div0)
            early_res = bus.op[1] ? a_fix : '1;
        else if (ovf)
            early_res = bus.op[1] ? '0 : a_fix;
    end
`endif

    logic [XLEN:0]   sum;
    logic [XLEN:0]   shl;
    logic [XLEN:0]   diff;
    logic [XLEN:0]   hi_nx;
    logic [XLEN-1:0] lo_nx;

    // Multiply shifts {hi,lo} right; divide shifts left and trial-subtracts.
    always_comb begin
        sum  = hi + (lo[0] ? {1'b0, b_q} : '0);
        shl  = {hi[XLEN-1:0], lo[XLEN-1]};
        diff = shl - {1'b0, b_q};
        if (op_q[2]) begin
            hi_nx = diff[XLEN] ? shl : diff;
            lo_nx = {lo[XLEN-2:0], ~diff[XLEN]};
        end else begin
            hi_nx = {1'b0, sum[XLEN:1]};
            lo_nx = {sum[0], lo[XLEN-1:1]};
        end
    end

    logic [2*XLEN-1:0] prod;
    logic [2*XLEN-1:0] prod_s;
    logic [XLEN-1:0]   quo;
    logic [XLEN-1:0]   rem;
    logic [XLEN-1:0]   fin;
    logic [XLEN-1:0]   fin_w;

    // Word multiplies leave the 32-bit product at the top of lo.
    always_comb begin
        prod   = {hi_nx[XLEN-1:0], lo_nx};
        prod_s = neg_q ? -prod : prod;
        quo    = lo_nx;
        rem    = hi_nx[XLEN-1:0];
        if (!op_q[2]) begin
            if (op_q[1:0] != 2'd0)
                fin = prod_s[2*XLEN-1:XLEN];
            else if (word_q)
                fin = XLEN'(lo_nx[XLEN-1 -: WLEN]);
            else
                fin = prod_s[XLEN-1:0];
        end else if (div0_q) begin
            fin = op_q[1] ? a_q : '1;
        end else if (op_q[1]) begin
            fin = rneg_q ? -rem : rem;
        end else begin
            fin = neg_q ? -quo : quo;
        end
        fin_w = word_q ? sext_w(fin) : fin;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            out_valid_q <= 1'b0;
            res_q       <= '0;
            cnt         <= '0;
        end else if (bus.flush) begin
            state       <= IDLE;
            out_valid_q <= 1'b0;
            cnt         <= '0;
        end else begin
            unique case (state)
                IDLE: if (bus.in_valid) begin
                    op_q   <= bus.op;
                    word_q <= wd;
                    neg_q  <= a_neg ^ b_neg;
                    rneg_q <= a_neg;
                    div0_q <= div0;
                    a_q    <= a_fix;
                    b_q    <= mag_b;
                    hi     <= '0;
                    lo     <= (is_div && wd) ? (mag_a << (XLEN - WLEN)) : mag_a;
                    cnt    <= wd ? CW'(WLEN) : CW'(XLEN);
`ifdef MULDIV_EARLY_OUT_EN
                    if (early) begin
                        state       <= DONE;
                        out_valid_q <= 1'b1;
                        res_q       <= early_res;
                    end else begin
                        state <= BUSY;
                    end
`else
                    state <= BUSY;
`endif
                end
                BUSY: begin
                    hi  <= hi_nx;
                    lo  <= lo_nx;
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        state       <= DONE;
                        out_valid_q <= 1'b1;
                        res_q       <= fin_w;
                    end
                end
                DONE: if (bus.out_ready) begin
                    state       <= IDLE;
                    out_valid_q <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.busy      = (state != IDLE);
    assign bus.out_valid = out_valid_q;
    assign bus.result    = res_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed-vector bench for muldiv_unit (XLEN=64), covering both
// MULDIV_EARLY_OUT_EN builds via matching latency expectations.
module tb_muldiv_unit;
    localparam int XLEN = 64;

`ifdef MULDIV_EARLY_OUT_EN
    localparam int LAT_X = 1;
    localparam int LAT_W = 1;
`else
    localparam int LAT_X = 65;
    localparam int LAT_W = 33;
`endif

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    muldiv_unit_if #(.XLEN(XLEN)) bus ();

    muldiv_unit #(.XLEN(XLEN), .WLEN(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic run(input string tag, input logic [2:0] op,
                       input logic w, input logic [63:0] a,
                       input logic [63:0] b, input logic [63:0] exp,
                       input int lat);
        int n;
        @(negedge clk);
        bus.op       = op;
        bus.word     = w;
        bus.src_a    = a;
        bus.src_b    = b;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.src_a    = ~a;
        bus.src_b    = a ^ 64'h5A5A_A5A5_0F0F_F0F0;
        n = 1;
        while (!bus.out_valid && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({tag, ".lat"}, 64'(n), 64'(lat));
        check(tag, bus.result, exp);
        repeat (3) @(posedge clk);
        #1;
        check({tag, ".hold"}, {63'd0, bus.out_valid}, 64'd1);
        check({tag, ".stable"}, bus.result, exp);
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        check({tag, ".drain"}, {62'd0, bus.out_valid, bus.in_ready}, 64'd1);
    endtask

    initial begin
        int seen;
        checks        = 0;
        errors        = 0;
        reset         = 1'b1;
        bus.flush     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.op        = 3'd0;
        bus.word      = 1'b0;
        bus.src_a     = '0;
        bus.src_b     = '0;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        check("rst.out_valid", {63'd0, bus.out_valid}, 64'd0);
        check("rst.busy", {63'd0, bus.busy}, 64'd0);
        check("rst.result", bus.result, 64'd0);
        check("rst.in_ready", {63'd0, bus.in_ready}, 64'd1);

        run("mul", 3'd0, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD,
            64'hFFFF_FFFF_FFFF_FFEB, 65);
        run("mulhu", 3'd3, 1'b0, '1, '1, 64'hFFFF_FFFF_FFFF_FFFE, 65);
        run("mulh", 3'd1, 1'b0, '1, '1, 64'd0, 65);
        run("mulhsu", 3'd2, 1'b0, '1, 64'd2, '1, 65);
        run("div", 3'd4, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2,
            64'hFFFF_FFFF_FFFF_FFFD, 65);
        run("rem", 3'd6, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, '1, 65);
        run("divu", 3'd5, 1'b0, 64'd100, 64'd7, 64'd14, 65);
        run("remu", 3'd7, 1'b0, 64'd100, 64'd7, 64'd2, 65);
        run("divuw", 3'd5, 1'b1, 64'h0000_0000_FFFF_FFFF, 64'd1, '1, 33);
        run("mulw", 3'd0, 1'b1, 64'hDEAD_BEEF_0000_0003,
            64'h1234_5678_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFA, 33);
        run("remw", 3'd6, 1'b1, 64'h0BAD_F00D_FFFF_FFF9,
            64'h7777_0000_0000_0002, '1, 33);
        run("div0", 3'd4, 1'b0, 64'd5, 64'd0, '1, LAT_X);
        run("rem0", 3'd6, 1'b0, 64'd5, 64'd0, 64'd5, LAT_X);
        run("divovf", 3'd4, 1'b0, 64'h8000_0000_0000_0000, '1,
            64'h8000_0000_0000_0000, LAT_X);
        run("removf", 3'd6, 1'b0, 64'h8000_0000_0000_0000, '1, 64'd0, LAT_X);
        run("divw0", 3'd4, 1'b1, 64'h1234_5678_FFFF_FFF0,
            64'hABCD_0000_0000_0000, '1, LAT_W);
        run("remw0", 3'd6, 1'b1, 64'h1234_5678_FFFF_FFF0,
            64'hABCD_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFF0, LAT_W);
        run("mulz", 3'd0, 1'b0, 64'd0, 64'h55, 64'd0, LAT_X);

        // Flush mid-iteration: unit returns to IDLE and never reports.
        @(negedge clk);
        bus.op       = 3'd4;
        bus.word     = 1'b0;
        bus.src_a    = 64'd100;
        bus.src_b    = 64'd7;
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (9) @(negedge clk);
        bus.flush = 1'b1;
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
        check("flush.busy", {63'd0, bus.busy}, 64'd0);
        check("flush.in_ready", {63'd0, bus.in_ready}, 64'd1);
        seen = 0;
        repeat (80) begin
            @(posedge clk);
            #1;
            if (bus.out_valid) seen++;
        end
        check("flush.no_out", 64'(seen), 64'd0);

        // Flush wins over a request presented in IDLE.
        @(negedge clk);
        bus.flush    = 1'b1;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        check("flushreq.in_ready", {63'd0, bus.in_ready}, 64'd1);
        check("flushreq.busy", {63'd0, bus.busy}, 64'd0);

        // Flush while DONE with out_ready drops the result.
        @(negedge clk);
        bus.op       = 3'd5;
        bus.word     = 1'b1;
        bus.src_a    = 64'd9;
        bus.src_b    = 64'd3;
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        seen = 0;
        while (!bus.out_valid && seen < 200) begin
            @(negedge clk);
            seen++;
        end
        check("flushdone.reach", 64'(seen), 64'd32);
        check("flushdone.result", bus.result, 64'd3);
        bus.flush     = 1'b1;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b0;
        check("flushdone.out_valid", {63'd0, bus.out_valid}, 64'd0);
        check("flushdone.in_ready", {63'd0, bus.in_ready}, 64'd1);

        run("after_flush", 3'd0, 1'b0, 64'd6, 64'd7, 64'd42, 65);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
